// File: rtl/read_stage_if.sv
// Read-stage bundle: decoded-instruction controls in, register file handshake, operands and PC command out.
// Pure wiring container; no logic or latency of its own.
// No backpressure: the stage consumes a new instruction every cycle.
interface read_stage_if;
  // Decoded instruction fields
  logic        imm_en;
  logic [4:0]  arg_imm;
  logic        read_a;
  logic [3:0]  arg_a;
  logic        read_b;
  logic [3:0]  arg_b;
  logic [2:0]  cmp_b;
  logic        pc_set;
  logic        pc_add;
  logic        pc_inc;
  logic [1:0]  pc_src;
  logic [1:0]  en_regs;
  logic        i_alu_en;
  logic [3:0]  i_truth_table;
  logic [4:0]  i_alu_op;
  logic        sh_off_imm;

  // Register file read port (request out, data back in the same cycle)
  logic [15:0] reg_a_value;
  logic [15:0] reg_b_value;
  logic        reg_a_read;
  logic        reg_b_read;
  logic [3:0]  reg_a;
  logic [3:0]  reg_b;

  // Registered results toward the execute stage
  logic        src_a_en;
  logic        src_b_en;
  logic [15:0] src_a;
  logic [15:0] src_b;
  logic        o_pc_set;
  logic        o_pc_add;
  logic        o_pc_inc;
  logic [30:0] pc;
  logic        o_alu_en;
  logic [3:0]  o_truth_table;
  logic [4:0]  o_alu_op;
  logic [3:0]  sh_off;

  // Upstream side: drives the instruction and register data, observes results
  modport master (
    output imm_en, arg_imm, read_a, arg_a, read_b, arg_b, cmp_b,
           pc_set, pc_add, pc_inc, pc_src, en_regs,
           i_alu_en, i_truth_table, i_alu_op, sh_off_imm,
           reg_a_value, reg_b_value,
    input  reg_a_read, reg_b_read, reg_a, reg_b,
           src_a_en, src_b_en, src_a, src_b,
           o_pc_set, o_pc_add, o_pc_inc, pc,
           o_alu_en, o_truth_table, o_alu_op, sh_off
  );

  // Read stage side
  modport slave (
    input  imm_en, arg_imm, read_a, arg_a, read_b, arg_b, cmp_b,
           pc_set, pc_add, pc_inc, pc_src, en_regs,
           i_alu_en, i_truth_table, i_alu_op, sh_off_imm,
           reg_a_value, reg_b_value,
    output reg_a_read, reg_b_read, reg_a, reg_b,
           src_a_en, src_b_en, src_a, src_b,
           o_pc_set, o_pc_add, o_pc_inc, pc,
           o_alu_en, o_truth_table, o_alu_op, sh_off
  );
endinterface

// File: rtl/read_stage.sv
// Read stage: fetches register operands, forms ALU operands, PC target and branch-qualified PC command.
// Latency: register file requests are combinational; every other output is registered, 1 cycle.
// No backpressure: a new instruction is accepted every cycle, there is no stall input.
module read_stage (
  input  logic          cpu_clk,
  input  logic          cpu_rst,
  read_stage_if.slave   bus
);

  // Register file request goes straight through so data returns in this same cycle
  always_comb begin
    bus.reg_a_read = bus.read_a;
    bus.reg_a      = bus.arg_a;
    bus.reg_b_read = bus.read_b;
    bus.reg_b      = bus.arg_b;
  end

  logic [15:0] a_val;
  logic [15:0] b_val;
  logic [15:0] imm_sext16;
  logic [30:0] imm_sext31;

  // Operand values: an unread register counts as zero; immediate is a signed 5-bit field
  always_comb begin
    a_val      = bus.read_a ? bus.reg_a_value : 16'h0000;
    b_val      = bus.read_b ? bus.reg_b_value : 16'h0000;
    imm_sext16 = {{11{bus.arg_imm[4]}}, bus.arg_imm};
    imm_sext31 = {{26{bus.arg_imm[4]}}, bus.arg_imm};
  end

  logic b_zero;
  logic b_neg;
  logic cond_true;

  // Branch condition on B as a signed 16-bit value
  always_comb begin
    b_zero    = (b_val == 16'h0000);
    b_neg     = b_val[15];
    cond_true = 1'b0;
    case (bus.cmp_b)
      3'd0:    cond_true = 1'b1;
      3'd1:    cond_true = b_zero;
      3'd2:    cond_true = !b_zero;
      3'd3:    cond_true = b_neg;
      3'd4:    cond_true = !b_neg;
      3'd5:    cond_true = !b_neg && !b_zero;
      3'd6:    cond_true = b_neg || b_zero;
      default: cond_true = 1'b0;
    endcase
  end

  logic        src_a_en_d, src_a_en_q;
  logic        src_b_en_d, src_b_en_q;
  logic [15:0] src_a_d, src_a_q;
  logic [15:0] src_b_d, src_b_q;
  logic        pc_set_d, pc_set_q;
  logic        pc_add_d, pc_add_q;
  logic        pc_inc_d, pc_inc_q;
  logic [30:0] pc_d, pc_q;
  logic        alu_en_d, alu_en_q;
  logic [3:0]  truth_table_d, truth_table_q;
  logic [4:0]  alu_op_d, alu_op_q;
  logic [3:0]  sh_off_d, sh_off_q;

  // Next-state for operands, ALU controls and shift offset
  always_comb begin
    src_a_en_d    = bus.en_regs[0];
    src_b_en_d    = bus.en_regs[1];
    src_a_d       = a_val;
    src_b_d       = bus.imm_en ? imm_sext16 : b_val;
    sh_off_d      = bus.sh_off_imm ? bus.arg_imm[3:0] : b_val[3:0];
    alu_en_d      = bus.i_alu_en;
    truth_table_d = bus.i_truth_table;
    alu_op_d      = bus.i_alu_op;
  end

  // PC target: concatenated pair, immediate, or A extended either way
  always_comb begin
    pc_d = 31'd0;
    case (bus.pc_src)
      2'd0:    pc_d = {a_val[14:0], b_val};
      2'd1:    pc_d = imm_sext31;
      2'd2:    pc_d = {{15{a_val[15]}}, a_val};
      default: pc_d = {15'd0, a_val};
    endcase
  end

  // PC command: a failed branch turns a jump into a plain increment; set wins over add
  always_comb begin
    pc_set_d = 1'b0;
    pc_add_d = 1'b0;
    pc_inc_d = bus.pc_inc;
    if (cond_true) begin
      pc_set_d = bus.pc_set;
      pc_add_d = bus.pc_add && !bus.pc_set;
    end else if (bus.pc_set || bus.pc_add) begin
      pc_inc_d = 1'b1;
    end
  end

  // Single pipeline register; async reset clears every registered output
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      src_a_en_q    <= 1'b0;
      src_b_en_q    <= 1'b0;
      src_a_q       <= 16'h0000;
      src_b_q       <= 16'h0000;
      pc_set_q      <= 1'b0;
      pc_add_q      <= 1'b0;
      pc_inc_q      <= 1'b0;
      pc_q          <= 31'd0;
      alu_en_q      <= 1'b0;
      truth_table_q <= 4'h0;
      alu_op_q      <= 5'h00;
      sh_off_q      <= 4'h0;
    end else begin
      src_a_en_q    <= src_a_en_d;
      src_b_en_q    <= src_b_en_d;
      src_a_q       <= src_a_d;
      src_b_q       <= src_b_d;
      pc_set_q      <= pc_set_d;
      pc_add_q      <= pc_add_d;
      pc_inc_q      <= pc_inc_d;
      pc_q          <= pc_d;
      alu_en_q      <= alu_en_d;
      truth_table_q <= truth_table_d;
      alu_op_q      <= alu_op_d;
      sh_off_q      <= sh_off_d;
    end
  end

  // Registered outputs onto the bundle
  always_comb begin
    bus.src_a_en      = src_a_en_q;
    bus.src_b_en      = src_b_en_q;
    bus.src_a         = src_a_q;
    bus.src_b         = src_b_q;
    bus.o_pc_set      = pc_set_q;
    bus.o_pc_add      = pc_add_q;
    bus.o_pc_inc      = pc_inc_q;
    bus.pc            = pc_q;
    bus.o_alu_en      = alu_en_q;
    bus.o_truth_table = truth_table_q;
    bus.o_alu_op      = alu_op_q;
    bus.sh_off        = sh_off_q;
  end

endmodule

// File: tb/tb_read_stage.sv
// Bench for read_stage: directed cases plus random instructions against an arithmetic reference model.
// Expected registered results are queued at issue and popped by a monitor one edge later.
// Combinational register requests and asynchronous reset are checked inline.
module tb_read_stage;

  logic cpu_clk;
  logic cpu_rst;
  read_stage_if bus ();

  read_stage dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .bus     (bus)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    bit        imm_en;
    bit [4:0]  imm;
    bit        ra;
    bit [3:0]  aa;
    bit        rb;
    bit [3:0]  ab;
    bit [2:0]  cmp;
    bit        set;
    bit        add;
    bit        inc;
    bit [1:0]  src;
    bit [1:0]  en;
    bit        alu_en;
    bit [3:0]  tt;
    bit [4:0]  op;
    bit        sh_imm;
    bit [15:0] rav;
    bit [15:0] rbv;
  } stim_t;

  typedef struct {
    bit [31:0] src_a_en, src_b_en, src_a, src_b;
    bit [31:0] pset, padd, pinc, pc;
    bit [31:0] alu_en, tt, op, sh_off;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: works from the instruction's meaning in plain integer arithmetic
  function automatic exp_t model(input stim_t s);
    exp_t   e;
    int     a, b, bs, imm, as_;
    longint v;
    bit     c;
    a   = s.ra ? int'(s.rav) : 0;
    b   = s.rb ? int'(s.rbv) : 0;
    bs  = (b >= 32768) ? b - 65536 : b;
    as_ = (a >= 32768) ? a - 65536 : a;
    imm = (s.imm >= 16) ? int'(s.imm) - 32 : int'(s.imm);
    e.src_a_en = s.en[0];
    e.src_b_en = s.en[1];
    e.src_a    = a;
    e.src_b    = s.imm_en ? (imm & 32'hFFFF) : b;
    e.sh_off   = s.sh_imm ? (s.imm % 16) : (b % 16);
    e.alu_en   = s.alu_en;
    e.tt       = s.tt;
    e.op       = s.op;
    case (s.src)
      2'd0:    v = longint'(a % 32768) * 65536 + b;
      2'd1:    v = imm;
      2'd2:    v = as_;
      default: v = a;
    endcase
    e.pc = 32'(v & 64'h7FFF_FFFF);
    case (s.cmp)
      3'd0: c = 1;
      3'd1: c = (bs == 0);
      3'd2: c = (bs != 0);
      3'd3: c = (bs < 0);
      3'd4: c = (bs >= 0);
      3'd5: c = (bs > 0);
      3'd6: c = (bs <= 0);
      default: c = 0;
    endcase
    if (c) begin
      e.pset = s.set;
      e.padd = s.add && !s.set;
      e.pinc = s.inc;
    end else if (s.set || s.add) begin
      e.pset = 0; e.padd = 0; e.pinc = 1;
    end else begin
      e.pset = 0; e.padd = 0; e.pinc = s.inc;
    end
    return e;
  endfunction

  function automatic bit [15:0] pick16();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'hFFFF;
      3: return 16'h8000;
      4: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.imm_en = 1'($urandom); s.imm = 5'($urandom);
    s.ra = ($urandom_range(0, 3) != 0); s.aa = 4'($urandom);
    s.rb = ($urandom_range(0, 3) != 0); s.ab = 4'($urandom);
    s.cmp = 3'($urandom);
    s.set = 1'($urandom); s.add = 1'($urandom); s.inc = 1'($urandom);
    s.src = 2'($urandom); s.en = 2'($urandom);
    s.alu_en = 1'($urandom); s.tt = 4'($urandom); s.op = 5'($urandom);
    s.sh_imm = 1'($urandom);
    s.rav = pick16(); s.rbv = pick16();
    return s;
  endfunction

  function automatic stim_t zero_stim();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  // Drive one instruction now, check the same-cycle register requests, queue the registered result
  task automatic apply_now(input stim_t s);
    bus.imm_en = s.imm_en; bus.arg_imm = s.imm;
    bus.read_a = s.ra; bus.arg_a = s.aa;
    bus.read_b = s.rb; bus.arg_b = s.ab;
    bus.cmp_b = s.cmp;
    bus.pc_set = s.set; bus.pc_add = s.add; bus.pc_inc = s.inc;
    bus.pc_src = s.src; bus.en_regs = s.en;
    bus.i_alu_en = s.alu_en; bus.i_truth_table = s.tt; bus.i_alu_op = s.op;
    bus.sh_off_imm = s.sh_imm;
    bus.reg_a_value = s.rav; bus.reg_b_value = s.rbv;
    #1;
    chk("reg_a_read", bus.reg_a_read, s.ra);
    chk("reg_a", bus.reg_a, s.aa);
    chk("reg_b_read", bus.reg_b_read, s.rb);
    chk("reg_b", bus.reg_b, s.ab);
    sb.push_back(model(s));
  endtask

  task automatic apply(input stim_t s);
    @(negedge cpu_clk);
    apply_now(s);
  endtask

  task automatic chk_regs_zero(input string tag);
    chk({tag, "_src"}, {bus.src_a, bus.src_b}, 32'd0);
    chk({tag, "_pc"}, {1'b0, bus.pc}, 32'd0);
    chk({tag, "_ctl"}, {16'd0, bus.src_a_en, bus.src_b_en, bus.o_pc_set, bus.o_pc_add,
                        bus.o_pc_inc, bus.o_alu_en, bus.o_truth_table, bus.o_alu_op, bus.sh_off}, 32'd0);
  endtask

  // Monitor: after each edge, compare the registered outputs with the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge cpu_clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("src_a_en", bus.src_a_en, e.src_a_en);
        chk("src_b_en", bus.src_b_en, e.src_b_en);
        chk("src_a", bus.src_a, e.src_a);
        chk("src_b", bus.src_b, e.src_b);
        chk("o_pc_set", bus.o_pc_set, e.pset);
        chk("o_pc_add", bus.o_pc_add, e.padd);
        chk("o_pc_inc", bus.o_pc_inc, e.pinc);
        chk("pc", {1'b0, bus.pc}, e.pc);
        chk("o_alu_en", bus.o_alu_en, e.alu_en);
        chk("o_truth_table", bus.o_truth_table, e.tt);
        chk("o_alu_op", bus.o_alu_op, e.op);
        chk("sh_off", bus.sh_off, e.sh_off);
      end
    end
  end

  initial begin
    stim_t s;
    cpu_rst = 1'b0;
    s = zero_stim();
    s.rav = 16'hFFFF; s.rbv = 16'hFFFF; s.imm = 5'h1F;
    s.set = 1; s.inc = 1; s.alu_en = 1; s.en = 2'b11;
    // Inputs busy but reset held: registered outputs stay zero across edges
    apply_now(s);
    void'(sb.pop_back());
    @(posedge cpu_clk); #1;
    chk_regs_zero("reset_state");

    // Release at a falling edge; the next rising edge captures normally
    @(negedge cpu_clk);
    cpu_rst = 1'b1;
    s = zero_stim();
    s.ra = 1; s.aa = 4'd3; s.rav = 16'h1234; s.en = 2'b01;
    apply_now(s);

    s = zero_stim();
    s.imm_en = 1; s.imm = 5'h1F; s.sh_imm = 1;
    apply(s);

    s = zero_stim();
    s.add = 1; s.cmp = 3'd1; s.rb = 1; s.rbv = 16'h0000; s.src = 2'd1; s.imm = 5'h10;
    apply(s);
    s.rbv = 16'h0001;
    apply(s);

    s = zero_stim();
    s.set = 1; s.src = 2'd0; s.ra = 1; s.rav = 16'hABCD; s.rb = 1; s.rbv = 16'h1234;
    apply(s);
    s.add = 1;
    apply(s);

    s = zero_stim();
    s.alu_en = 1; s.tt = 4'h6; s.op = 5'h11;
    apply(s);

    for (int i = 0; i < 400; i++) apply(rand_stim());

    s = zero_stim();
    s.ra = 1; s.rav = 16'hBEEF; s.rb = 1; s.rbv = 16'h8001; s.src = 2'd3;
    s.en = 2'b11; s.alu_en = 1; s.tt = 4'hA; s.op = 5'h1F; s.inc = 1;
    apply(s);

    // Mid-operation reset: outputs drop before any further edge, requests keep following inputs
    @(posedge cpu_clk); #3;
    chk("queue_drained", sb.size(), 0);
    chk("pre_reset_nonzero", {31'd0, (bus.src_a != 16'h0000)}, 32'd1);
    cpu_rst = 1'b0;
    #1;
    chk_regs_zero("async_reset");
    bus.arg_a = 4'd9;
    #1;
    chk("reg_a_in_reset", bus.reg_a, 4'd9);
    @(posedge cpu_clk); #1;
    chk_regs_zero("reset_held");

    @(negedge cpu_clk);
    cpu_rst = 1'b1;
    apply_now(rand_stim());
    for (int i = 0; i < 200; i++) apply(rand_stim());

    @(posedge cpu_clk); #3;
    chk("final_queue", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
